// File: rtl/dec_pkg.sv
// Shared constants and helpers for the registered one-hot decoder.
package dec_pkg;

  localparam int unsigned SEL_W_DEFAULT = 8;
  localparam int unsigned OUT_W_DEFAULT = 256;

  // A registered decode is bad if it is not exactly one-hot while valid,
  // or if it has any bit set while idle.
  function automatic logic onehot_bad(input logic [OUT_W_DEFAULT-1:0] vec,
                                      input logic                     vld);
    logic single;
    single = (vec != '0) && ((vec & (vec - OUT_W_DEFAULT'(1))) == '0);
    return vld ? !single : (vec != '0);
  endfunction

endpackage

// File: rtl/dec_pre_half.sv
// Combinational half-width predecoder: IN_W-bit binary to 2**IN_W one-hot.
module dec_pre_half #(
  parameter int unsigned IN_W = 4,
  localparam int unsigned DEC_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  idx,
  output logic [DEC_W-1:0] dec
);

  // Exactly one output line follows the index; every code is legal.
  always_comb begin
    dec      = '0;
    dec[idx] = 1'b1;
  end

endmodule

// File: rtl/dec8_onehot_reg.sv
// Registered binary-to-one-hot decoder with one cycle of latency.
// Two half-width predecoders feed an AND matrix in front of the output flops.
// Optional build macro DEC_SEL_ECHO_EN adds a registered sel echo (sel_q)
// and a debug flag (onehot_err) that flags a corrupted output register.
// SEL_W must be even and within 2..8.
module dec8_onehot_reg
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEFAULT,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [OUT_W-1:0] onehot
`ifdef DEC_SEL_ECHO_EN
  ,
  output logic [SEL_W-1:0] sel_q,
  output logic             onehot_err
`endif
);

  localparam int unsigned HalfW = SEL_W / 2;
  localparam int unsigned HalfN = 2 ** HalfW;

  logic [HalfN-1:0] lo_dec;
  logic [HalfN-1:0] hi_dec;
  logic [OUT_W-1:0] full_dec;
  logic [OUT_W-1:0] onehot_d, onehot_q;
  logic             out_valid_q;

  dec_pre_half #(
    .IN_W (HalfW)
  ) u_pre_lo (
    .idx (sel[HalfW-1:0]),
    .dec (lo_dec)
  );

  dec_pre_half #(
    .IN_W (HalfW)
  ) u_pre_hi (
    .idx (sel[SEL_W-1:HalfW]),
    .dec (hi_dec)
  );

  // Bit k = hi[k / HalfN] & lo[k % HalfN].
  for (genvar h = 0; h < HalfN; h++) begin : g_row
    for (genvar l = 0; l < HalfN; l++) begin : g_col
      assign full_dec[h*HalfN + l] = hi_dec[h] & lo_dec[l];
    end
  end

  // Idle cycles clear the output so a stale index is never presented; the
  // mux also keeps an undriven sel from reaching the flops while idle.
  always_comb begin
    onehot_d = in_valid ? full_dec : '0;
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      onehot_q    <= onehot_d;
      out_valid_q <= in_valid;
    end
  end

  assign onehot    = onehot_q;
  assign out_valid = out_valid_q;

`ifdef DEC_SEL_ECHO_EN
  logic [SEL_W-1:0] sel_echo_q;
  logic             err_q;

  // Echo the captured index and check the output register one cycle behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_echo_q <= '0;
      err_q      <= 1'b0;
    end else begin
      sel_echo_q <= in_valid ? sel : '0;
      err_q      <= onehot_bad(OUT_W_DEFAULT'(onehot_q), out_valid_q);
    end
  end

  assign sel_q      = sel_echo_q;
  assign onehot_err = err_q;
`endif

endmodule

// File: tb/tb_dec8_onehot_reg.sv
// Directed and random self-checking bench for dec8_onehot_reg.
module tb_dec8_onehot_reg;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   sel;
  logic         out_valid;
  logic [255:0] onehot;
`ifdef DEC_SEL_ECHO_EN
  logic [7:0]   sel_q;
  logic         onehot_err;
`endif

  int checks;
  int failures;

  dec8_onehot_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sel       (sel),
    .out_valid (out_valid),
    .onehot    (onehot)
`ifdef DEC_SEL_ECHO_EN
    ,
    .sel_q      (sel_q),
    .onehot_err (onehot_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then sample just after the capturing edge.
  task automatic step(input logic v, input logic [7:0] s);
    @(negedge clk);
    in_valid = v;
    sel      = s;
    @(posedge clk);
    #1;
  endtask

  logic [255:0] exp_oh;
  logic [255:0] one;
  logic         rv;
  logic [7:0]   rs;

  initial begin
    checks   = 0;
    failures = 0;
    one      = 256'd1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 8'h00;
    #12;
    chk("reset_onehot", onehot, 256'd0);
    chk("reset_valid", {255'd0, out_valid}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Concrete decode points.
    step(1'b1, 8'h00);
    chk("sel00", onehot, 256'h1);
    chk("sel00_valid", {255'd0, out_valid}, 256'd1);
    step(1'b1, 8'h01);
    chk("sel01", onehot, 256'h2);
    step(1'b1, 8'hFF);
    chk("selFF", onehot, {1'b1, 255'd0});
    step(1'b1, 8'h0F);
    chk("sel0F", onehot, 256'h8000);
    step(1'b1, 8'h10);
    chk("sel10", onehot, 256'h1_0000);
    step(1'b1, 8'hF0);
    chk("selF0", onehot, {16'h0001, 240'd0});

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i));
      chk("sweep", onehot, one << i);
      chk("sweep_valid", {255'd0, out_valid}, 256'd1);
    end

    // Idle clears the output; undriven sel while idle is ignored.
    step(1'b0, 8'h33);
    chk("idle33", onehot, 256'd0);
    chk("idle33_valid", {255'd0, out_valid}, 256'd0);
    step(1'b0, 8'hxx);
    chk("idle_x", onehot, 256'd0);
    chk("idle_x_valid", {255'd0, out_valid}, 256'd0);

    // Toggle in_valid with sel=0x80.
    step(1'b1, 8'h80);
    chk("tog1", onehot, {127'd0, 1'b1, 128'd0});
    step(1'b0, 8'h80);
    chk("tog0", onehot, 256'd0);
    step(1'b1, 8'h80);
    chk("tog1b", onehot, {127'd0, 1'b1, 128'd0});

    // Asynchronous reset away from any clock edge.
    in_valid = 1'b1;
    sel      = 8'h5A;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_onehot", onehot, 256'd0);
    chk("async_rst_valid", {255'd0, out_valid}, 256'd0);
    @(posedge clk);
    #1;
    chk("rst_held_onehot", onehot, 256'd0);
    chk("rst_held_valid", {255'd0, out_valid}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h5A);
    chk("post_rst", onehot, one << 8'h5A);

    // Random traffic: model compare plus popcount invariant.
    for (int i = 0; i < 10000; i++) begin
      rv = 1'($urandom_range(0, 1));
      rs = 8'($urandom_range(0, 255));
      step(rv, rs);
      exp_oh = rv ? (one << rs) : 256'd0;
      chk("rand_onehot", onehot, exp_oh);
      chk("rand_popcount", 256'($countones(onehot)), {255'd0, out_valid});
    end

`ifdef DEC_SEL_ECHO_EN
    step(1'b1, 8'hA7);
    chk("echo_sel", {248'd0, sel_q}, 256'hA7);
    chk("echo_err0", {255'd0, onehot_err}, 256'd0);
    step(1'b0, 8'hA7);
    chk("echo_idle", {248'd0, sel_q}, 256'd0);
    @(negedge clk);
    in_valid = 1'b1;
    sel      = 8'h01;
    @(posedge clk);
    #1;
    @(negedge clk);
    force dut.onehot_q = 256'h3;
    @(posedge clk);
    #1;
    chk("echo_err1", {255'd0, onehot_err}, 256'd1);
    @(negedge clk);
    release dut.onehot_q;
    step(1'b1, 8'h01);
    step(1'b1, 8'h01);
    chk("echo_err_clr", {255'd0, onehot_err}, 256'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
